if_ctrl: RTL and testbench
==========================

# if_ctrl

Instruction-fetch controller for the OpenMIPS front end. It owns the program counter and issues fetch requests to instruction memory over a req/ack handshake, which supports zero-wait and multi-cycle memories. Fetched instructions go into a two-entry buffer (slot plus skid) that feeds the IF/ID stage. Branch redirects and exception flushes reposition the fetch stream; any in-flight memory transaction is drained and its data discarded.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous assert, active-low; synchronous release assumed from system reset sync
- stall_i  in  1  IF/ID not accepting; instruction consumed at edge where inst_valid_o && !stall_i
- redirect_i  in  1  branch/jump taken, one-cycle pulse
- redirect_pc_i  in  ADDR_W  branch target
- flush_i  in  1  exception flush, one-cycle pulse; priority over redirect_i
- flush_pc_i  in  ADDR_W  exception vector
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, stable while imem_req && !imem_ack
- imem_ack  in  1  transfer complete at this edge; ignored when imem_req=0
- imem_rdata  in  DATA_W  instruction, valid with imem_ack
- inst_valid_o  out  1  slot holds valid instruction
- inst_o  out  DATA_W  instruction in slot
- inst_pc_o  out  ADDR_W  address of inst_o

## Operation
- Registers: pc (next fetch address), slot {valid, inst, pc}, skid {valid, inst, pc}, state.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: imem_req=0; always goes to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc.
  - On ack: pc<=pc+4. Data is loaded into the slot if the slot is empty or consumed this edge. Otherwise it goes to the skid.
  - Next state is HOLD if the skid becomes valid; else stays in REQ.
- HOLD: imem_req=0. When the slot is consumed, skid moves to slot and skid is cleared. Next state is REQ.
- Consumption with slot valid, skid empty, no ack: slot is cleared.
- Redirect/flush at an edge (flush wins over redirect):
  - pc<=target.
  - slot and skid are cleared.
  - Data from an ack at the same edge is discarded.
  - If in REQ without ack: go to DRAIN. Otherwise go to REQ.
- DRAIN: imem_req=1 with the old address held. On ack, data is discarded and the next state is REQ.
  - A new redirect/flush in DRAIN updates pc. The state stays DRAIN unless ack arrives at that same edge.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Memory transactions are never aborted; imem_req never drops before ack.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, skid empty.
- Reset asserted mid-transaction: all of the above apply immediately. The memory must tolerate the request being abandoned.
- Edge 1 after release: IDLE->REQ. Edge 2 earliest ack. inst_valid_o is high in the cycle after the ack edge.
- Zero-wait memory without stall: one instruction per cycle, addresses consecutive.
- Latency from redirect edge to imem_addr=target:
  - 0 cycles when no fetch is outstanding (imem_addr shows the target in the next cycle).
  - Otherwise, after the drain ack.
- inst_valid_o is low in the cycle after a redirect/flush edge.
- The skid bounds the buffer. At most one outstanding request exists; no overflow is possible.

## Configuration
- IF_CTRL_ALIGN_CHECK_EN defined: adds output fetch_err_o (1 bit, reset 0).
  - A redirect/flush target with addr[1:0]!=0 sets fetch_err_o to 1 and clears the buffer.
  - Any outstanding transaction is drained; then the block waits in IDLE with imem_req=0.
  - fetch_err_o is sticky. An aligned flush_i clears it and resumes fetch at the flush target. Redirects are ignored while it is set.
- Not defined: no fetch_err_o port. Target bits [1:0] are forced to 0.

## Test plan
- Reset/start: release rst with a zero-wait memory returning 32'h1000_0000+addr -> imem_addr is 0,4,8,... back-to-back, inst_pc_o tracks it, and inst_o=32'h1000_0000+inst_pc_o.
- Stall: hold stall_i for 5 cycles while imem_ack is always 1 -> skid fills, imem_req drops, and inst_o is held. On release, the next two instructions are delivered in order with no loss or duplication.
- Multi-cycle memory with 3-cycle ack latency: redirect to 32'h0000_0100 in the 2nd wait cycle -> imem_addr holds the old address until ack, the data is discarded, and the next request is to 0x100.
- Simultaneous events: flush_i(0x180) and redirect_i(0x200) on the same edge as an ack -> the acked data is dropped and the next imem_addr is 0x180.
- Wrap: redirect to 32'hFFFF_FFFC -> the following fetch address is 0.
- With IF_CTRL_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_err_o=1 and fetch stops. An aligned flush_i to 0x180 then clears it and fetch resumes at 0x180. Without the macro, the same redirect fetches 0x100.

Source files
------------

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake and
// buffers fetched words in a slot + skid pair. Optional IF_CTRL_ALIGN_CHECK_EN adds fetch_err_o.
//   state | meaning
//   IDLE  | no request; leaves for REQ unless halted on an alignment error
//   REQ   | request at pc outstanding
//   HOLD  | skid full, request paused until the slot is consumed
//   DRAIN | stale request completing, its data is dropped
module if_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
`ifdef IF_CTRL_ALIGN_CHECK_EN
    output logic              fetch_err_o,
`endif
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic              slot_v_q, slot_v_d;
    logic [DATA_W-1:0] slot_inst_q, slot_inst_d;
    logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic              ack, consume, redir, bad, halt;
    logic [ADDR_W-1:0] tgt_raw, tgt;

    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign ack       = imem_req && imem_ack;
    assign consume   = slot_v_q && !stall_i;
    assign tgt_raw   = flush_i ? flush_pc_i : redirect_pc_i;

`ifdef IF_CTRL_ALIGN_CHECK_EN
    logic err_q, err_d;

    // While the error is latched only an exception flush can restart fetch.
    assign redir       = flush_i || (redirect_i && !err_q);
    assign tgt         = tgt_raw;
    assign bad         = (tgt_raw[1:0] != 2'b00);
    assign halt        = err_q;
    assign err_d       = redir ? bad : err_q;
    assign fetch_err_o = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    assign redir = flush_i || redirect_i;
    assign tgt   = tgt_raw & ~ADDR_W'(3);
    assign bad   = 1'b0;
    assign halt  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        slot_v_d     = slot_v_q;
        slot_inst_d  = slot_inst_q;
        slot_pc_d    = slot_pc_q;
        skid_v_d     = skid_v_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (consume) slot_v_d = 1'b0;

        case (state_q)
            IDLE: if (!halt) state_d = REQ;
            REQ: begin
                if (ack) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (!slot_v_q || consume) begin
                        slot_v_d    = 1'b1;
                        slot_inst_d = imem_rdata;
                        slot_pc_d   = pc_q;
                    end else begin
                        skid_v_d    = 1'b1;
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    slot_v_d    = skid_v_q;
                    slot_inst_d = skid_inst_q;
                    slot_pc_d   = skid_pc_q;
                    skid_v_d    = 1'b0;
                    state_d     = REQ;
                end
            end
            DRAIN: if (ack) state_d = halt ? IDLE : REQ;
            default: state_d = IDLE;
        endcase

        // Redirects override everything above; an open request must still complete.
        if (redir) begin
            slot_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (state_q == REQ && !ack) drain_addr_d = pc_q;
            if (!bad) pc_d = tgt;
            if (imem_req && !ack) state_d = DRAIN;
            else if (bad)         state_d = IDLE;
            else                  state_d = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            slot_v_q     <= 1'b0;
            slot_inst_q  <= '0;
            slot_pc_q    <= '0;
            skid_v_q     <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            slot_v_q     <= slot_v_d;
            slot_inst_q  <= slot_inst_d;
            slot_pc_q    <= slot_pc_d;
            skid_v_q     <= skid_v_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign inst_valid_o = slot_v_q;
    assign inst_o       = slot_inst_q;
    assign inst_pc_o    = slot_pc_q;

endmodule

// File: tb/tb_if_ctrl.sv
// Scoreboard bench for if_ctrl: a behavioural memory answers requests, expected
// fetches are queued on ack and compared when IF/ID consumes them.
module tb_if_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, redirect_i, flush_i;
    logic [31:0] redirect_pc_i, flush_pc_i;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid_o;
    logic [31:0] inst_o, inst_pc_o;
`ifdef IF_CTRL_ALIGN_CHECK_EN
    logic        fetch_err_o;
`endif

    always #5 clk = ~clk;

    if_ctrl dut (
        .clk(clk), .rst(rst),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
`ifdef IF_CTRL_ALIGN_CHECK_EN
        .fetch_err_o(fetch_err_o),
`endif
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc, drain_addr, arm_pc;
    bit          draining, err_m, after_redir, ack_always, armed, arm_hit;
    int          waits, wait_cnt, arm_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc = 32'h0; drain_addr = 32'h0;
        draining = 0; err_m = 0; after_redir = 0; wait_cnt = 0; armed = 0;
    endtask

    // One clock: drive inputs and memory response at negedge, then update the model for the coming edge.
    task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit f, input logic [31:0] fp);
        bit          acc, rv, cons;
        logic [31:0] tgt;
        ent_t        e;
        @(negedge clk);
        if (armed && imem_req && !draining && wait_cnt == arm_cnt) begin
            r = 1; rp = arm_pc; armed = 0; arm_hit = 1;
        end
        stall_i = s; redirect_i = r; redirect_pc_i = rp; flush_i = f; flush_pc_i = fp;
        imem_ack   = ack_always || (imem_req && wait_cnt >= waits);
        imem_rdata = 32'h1000_0000 + imem_addr;
        #1;
        acc = imem_req && imem_ack;
        rv  = f || (r && !err_m);
        if (after_redir) check("valid_after_redirect", inst_valid_o, 0);
        after_redir = 0;
        if (err_m && !draining) check("req_while_err", imem_req, 0);
        if (imem_req) check("imem_addr", imem_addr, draining ? drain_addr : exp_pc);
        cons = inst_valid_o && !s;
        if (cons) begin
            if (sb.size() == 0) check("valid_with_empty_sb", inst_valid_o, 0);
            else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc_o, e.pc);
                check("inst", inst_o, e.inst);
            end
        end
        if (acc) begin
            if (draining) draining = 0;
            else if (!rv) begin
                sb.push_back('{exp_pc, 32'h1000_0000 + exp_pc});
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rv) begin
            tgt = f ? fp : rp;
            sb.delete();
            after_redir = 1;
            if (imem_req && !imem_ack) begin
                if (!draining) drain_addr = exp_pc;
                draining = 1;
            end else draining = 0;
`ifdef IF_CTRL_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) err_m = 1;
            else begin
                err_m  = 0;
                exp_pc = tgt;
            end
`else
            exp_pc = {tgt[31:2], 2'b00};
`endif
        end
        if (imem_req && !imem_ack) wait_cnt++;
        else wait_cnt = 0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 32'h0);
    endtask

    logic [31:0] held_pc, held_inst;
    int          guard;

    initial begin
        rst = 1'b0;
        stall_i = 0; redirect_i = 0; flush_i = 0; redirect_pc_i = 0; flush_pc_i = 0;
        imem_ack = 0; imem_rdata = 0;
        ack_always = 0; waits = 0; arm_hit = 0; arm_cnt = 0; arm_pc = 0;
        model_reset();
        #12;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", inst_valid_o, 0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
`ifdef IF_CTRL_ALIGN_CHECK_EN
        check("rst_fetch_err", fetch_err_o, 0);
`endif
        @(negedge clk) rst = 1'b1;

        // Zero-wait streaming
        idle_steps(20);
        check("stream_valid", inst_valid_o, 1);
        check("stream_sb_depth", sb.size(), 1);

        // Stall with ack permanently high
        ack_always = 1;
        step(1, 0, 0, 0, 0);
        held_pc = inst_pc_o; held_inst = inst_o;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        check("stall_req_dropped", imem_req, 0);
        check("stall_pc_held", inst_pc_o, held_pc);
        check("stall_inst_held", inst_o, held_inst);
        check("stall_sb_depth", sb.size(), 2);
        ack_always = 0;
        idle_steps(10);

        // Three-cycle memory, redirect in the second wait cycle
        waits = 2; arm_cnt = 1; arm_pc = 32'h0000_0100; arm_hit = 0; armed = 1;
        guard = 0;
        while (!arm_hit && guard < 20) begin idle_steps(1); guard++; end
        check("arm_hit", arm_hit, 1);
        guard = 0;
        while (draining && guard < 10) begin idle_steps(1); guard++; end
        check("drain_done", draining, 0);
        idle_steps(1);
        check("addr_after_drain", imem_addr, 32'h0000_0100);
        idle_steps(12);

        // Flush and redirect together on an ack edge
        waits = 0;
        idle_steps(4);
        check("req_before_flush", imem_req, 1);
        step(0, 1, 32'h200, 1, 32'h180);
        idle_steps(1);
        check("flush_wins_addr", imem_addr, 32'h180);
        idle_steps(6);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        idle_steps(1);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        idle_steps(1);
        check("wrap_addr_zero", imem_addr, 32'h0);
        idle_steps(6);

        // Misaligned redirect target
        step(0, 1, 32'h102, 0, 0);
`ifdef IF_CTRL_ALIGN_CHECK_EN
        idle_steps(1);
        check("err_set", fetch_err_o, 1);
        idle_steps(2);
        step(0, 1, 32'h300, 0, 0);
        idle_steps(1);
        check("err_sticky", fetch_err_o, 1);
        check("err_no_req", imem_req, 0);
        step(0, 0, 0, 1, 32'h180);
        idle_steps(1);
        check("err_cleared", fetch_err_o, 0);
        check("resume_addr", imem_addr, 32'h180);
`else
        idle_steps(1);
        check("misaligned_masked", imem_addr, 32'h100);
`endif
        idle_steps(6);

        // Reset in the middle of a multi-cycle transaction
        waits = 3;
        guard = 0;
        while (!(imem_req && wait_cnt == 1) && guard < 20) begin idle_steps(1); guard++; end
        check("mid_txn_reached", imem_req, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", inst_valid_o, 0);
        model_reset();
        waits = 0;
        @(negedge clk) rst = 1'b1;
        idle_steps(10);
        check("restart_valid", inst_valid_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
